// File: rtl/qif_neuron_param_if.sv
// Bus between a synaptic-current source and one QIF neuron.
// The source (master) drives the step strobe, current and gain; the neuron
// (slave) returns membrane voltage, spike pulse, refractory flag and count.
interface qif_neuron_param_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  logic                      step_en;
  logic signed [WIDTH-1:0]   I_syn;
  logic [7:0]                gain;
  logic signed [WIDTH-1:0]   V_mem;
  logic                      spike;
  logic                      refractory;
  logic [COUNT_W-1:0]        spike_count;

  modport master (
    output step_en, I_syn, gain,
    input  V_mem, spike, refractory, spike_count
  );

  modport slave (
    input  step_en, I_syn, gain,
    output V_mem, spike, refractory, spike_count
  );
endinterface

// File: rtl/qif_neuron_param.sv
// Parametrised quadratic integrate-and-fire neuron.
// Each step_en strobe integrates V' = V + ((V*V*gain) >> GAIN_SHIFT) + I_syn
// at full precision, fires when the unsaturated sum reaches V_PEAK, then
// optionally holds V at V_RESET for REFRAC further strobes.
module qif_neuron_param #(
  parameter int WIDTH      = 8,
  parameter int GAIN_SHIFT = 7,
  parameter int V_PEAK     = 50,
  parameter int V_RESET    = -20,
  parameter int V_INIT     = 0,
  parameter int REFRAC     = 2,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  qif_neuron_param_if.slave  bus
);

  // Internal widths: square, scaled square, and the full-precision sum that
  // can never overflow for any V, I_syn and gain.
  localparam int SQ_W  = 2 * WIDTH;
  localparam int Q_W   = SQ_W + 8;
  localparam int SUM_W = SQ_W + 10;
  localparam int RC_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);
  localparam logic signed [WIDTH-1:0] V_INIT_W  = WIDTH'(V_INIT);
  localparam logic signed [WIDTH-1:0] V_MAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] V_MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic signed [SUM_W-1:0] PEAK_S    = SUM_W'(V_PEAK);
  localparam logic signed [SUM_W-1:0] SAT_MAX_S = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN_S = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  localparam logic [RC_W-1:0]    REFRAC_LOAD = RC_W'(REFRAC);
  localparam logic [RC_W-1:0]    RC_ONE      = RC_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE   = COUNT_W'(1);

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRAC    = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   v_mem_q, v_mem_d;
  logic                      spike_q, spike_d;
  logic                      refractory_q, refractory_d;
  logic [RC_W-1:0]           refrac_cnt_q, refrac_cnt_d;
  logic [COUNT_W-1:0]        spike_count_q, spike_count_d;

  logic signed [SQ_W-1:0]    v_ext;
  logic signed [SQ_W-1:0]    sq_s;
  logic [SQ_W-1:0]           sq;
  logic [Q_W-1:0]            prod;
  logic [Q_W-1:0]            q;
  logic signed [SUM_W-1:0]   sum;
  logic                      crossed;
  logic signed [WIDTH-1:0]   v_sat;

  // Quadratic update at full precision; V*V is always non-negative and fits
  // in 2*WIDTH bits, so the scaled term is shifted logically.
  always_comb begin
    v_ext   = {{WIDTH{v_mem_q[WIDTH-1]}}, v_mem_q};
    sq_s    = v_ext * v_ext;
    sq      = $unsigned(sq_s);
    prod    = {8'd0, sq} * {{SQ_W{1'b0}}, bus.gain};
    q       = prod >> GAIN_SHIFT;
    sum     = $signed({2'b00, q})
            + $signed({{(SUM_W-WIDTH){v_mem_q[WIDTH-1]}}, v_mem_q})
            + $signed({{(SUM_W-WIDTH){bus.I_syn[WIDTH-1]}}, bus.I_syn});
    crossed = (sum >= PEAK_S);
    if (sum > SAT_MAX_S) begin
      v_sat = V_MAX_W;
    end else if (sum < SAT_MIN_S) begin
      v_sat = V_MIN_W;
    end else begin
      v_sat = sum[WIDTH-1:0];
    end
  end

  // Next-state decision: hold when not stepping, integrate or fire in
  // INTEGRATE, count down the hold period in REFRAC.
  always_comb begin
    state_d       = state_q;
    v_mem_d       = v_mem_q;
    spike_d       = 1'b0;
    refractory_d  = refractory_q;
    refrac_cnt_d  = refrac_cnt_q;
    spike_count_d = spike_count_q;
    if (bus.step_en) begin
      case (state_q)
        ST_INTEGRATE: begin
          if (crossed) begin
            v_mem_d       = V_RESET_W;
            spike_d       = 1'b1;
            spike_count_d = spike_count_q + COUNT_ONE;
            if (REFRAC > 0) begin
              state_d      = ST_REFRAC;
              refrac_cnt_d = REFRAC_LOAD;
              refractory_d = 1'b1;
            end
          end else begin
            v_mem_d = v_sat;
          end
        end
        ST_REFRAC: begin
          v_mem_d = V_RESET_W;
          if (refrac_cnt_q <= RC_ONE) begin
            state_d      = ST_INTEGRATE;
            refrac_cnt_d = '0;
            refractory_d = 1'b0;
          end else begin
            refrac_cnt_d = refrac_cnt_q - RC_ONE;
          end
        end
        default: begin
          state_d      = ST_INTEGRATE;
          refrac_cnt_d = '0;
          refractory_d = 1'b0;
        end
      endcase
    end
  end

  // All neuron state, with reset returning immediately to the initial values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INTEGRATE;
      v_mem_q       <= V_INIT_W;
      spike_q       <= 1'b0;
      refractory_q  <= 1'b0;
      refrac_cnt_q  <= '0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      v_mem_q       <= v_mem_d;
      spike_q       <= spike_d;
      refractory_q  <= refractory_d;
      refrac_cnt_q  <= refrac_cnt_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign bus.V_mem       = v_mem_q;
  assign bus.spike       = spike_q;
  assign bus.refractory  = refractory_q;
  assign bus.spike_count = spike_count_q;

endmodule

// File: tb/tb_qif_neuron_param.sv
// Testbench for qif_neuron_param: two instances (REFRAC=2/COUNT_W=16 and
// REFRAC=0/COUNT_W=2) driven with identical stimulus, checked against
// directed expectations and an arithmetic reference model.
module tb_qif_neuron_param;

  localparam int WIDTH      = 8;
  localparam int GAIN_SHIFT = 7;
  localparam int V_PEAK     = 50;
  localparam int V_RESET    = -20;
  localparam int V_INIT     = 0;

  logic clk = 1'b0;
  logic reset;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_v[2];
  int m_rc[2];
  int m_cnt[2];
  bit m_spk[2];
  int m_refrac[2] = '{2, 0};
  int m_cw[2]     = '{16, 2};

  always #5 clk = ~clk;

  qif_neuron_param_if #(.WIDTH(WIDTH), .COUNT_W(16)) bus_a ();
  qif_neuron_param_if #(.WIDTH(WIDTH), .COUNT_W(2))  bus_b ();

  qif_neuron_param #(
    .WIDTH(WIDTH), .GAIN_SHIFT(GAIN_SHIFT), .V_PEAK(V_PEAK), .V_RESET(V_RESET),
    .V_INIT(V_INIT), .REFRAC(2), .COUNT_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  qif_neuron_param #(
    .WIDTH(WIDTH), .GAIN_SHIFT(GAIN_SHIFT), .V_PEAK(V_PEAK), .V_RESET(V_RESET),
    .V_INIT(V_INIT), .REFRAC(0), .COUNT_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Reference model: plain integer arithmetic of one neuron step.
  function automatic void model_reset();
    for (int id = 0; id < 2; id++) begin
      m_v[id]   = V_INIT;
      m_rc[id]  = 0;
      m_cnt[id] = 0;
      m_spk[id] = 0;
    end
  endfunction

  function automatic void model_step(int id, bit en, int i, int g);
    longint s;
    m_spk[id] = 0;
    if (!en) return;
    if (m_rc[id] > 0) begin
      m_rc[id] = m_rc[id] - 1;
      m_v[id]  = V_RESET;
      return;
    end
    s = longint'(m_v[id]) + ((longint'(m_v[id]) * m_v[id] * g) >>> GAIN_SHIFT) + i;
    if (s >= V_PEAK) begin
      m_v[id]   = V_RESET;
      m_spk[id] = 1;
      m_cnt[id] = (m_cnt[id] + 1) % (1 << m_cw[id]);
      m_rc[id]  = m_refrac[id];
    end else if (s > 127) begin
      m_v[id] = 127;
    end else if (s < -128) begin
      m_v[id] = -128;
    end else begin
      m_v[id] = int'(s);
    end
  endfunction

  function automatic logic [25:0] exp_a();
    return {WIDTH'(m_v[0]), m_spk[0], (m_rc[0] > 0), 16'(m_cnt[0])};
  endfunction

  function automatic logic [11:0] exp_b();
    return {WIDTH'(m_v[1]), m_spk[1], (m_rc[1] > 0), 2'(m_cnt[1])};
  endfunction

  // Drive one cycle from a falling edge to the next falling edge.
  task automatic drive(input bit en, input int i, input int g);
    bus_a.step_en = en;  bus_a.I_syn = WIDTH'(i);  bus_a.gain = 8'(g);
    bus_b.step_en = en;  bus_b.I_syn = WIDTH'(i);  bus_b.gain = 8'(g);
    @(posedge clk);
    model_step(0, en, i, g);
    model_step(1, en, i, g);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus_a.step_en = 1'b0;  bus_a.I_syn = '0;  bus_a.gain = '0;
    bus_b.step_en = 1'b0;  bus_b.I_syn = '0;  bus_b.gain = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus_a.step_en = 1'b1;  bus_a.I_syn = WIDTH'(100);  bus_a.gain = 8'd32;
    bus_b.step_en = 1'b1;  bus_b.I_syn = WIDTH'(100);  bus_b.gain = 8'd32;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count} !== {WIDTH'(V_INIT), 1'b0, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_a: got %h want %h", {bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count}, {WIDTH'(V_INIT), 1'b0, 1'b0, 16'd0});
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count} !== {WIDTH'(V_INIT), 1'b0, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_dominates_b: got %h want %h", {bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count}, {WIDTH'(V_INIT), 1'b0, 1'b0, 2'd0});
    end
    do_reset();
  endtask

  task automatic test_basic_spike();
    int ev[3] = '{10, 45, -20};
    bit es[3] = '{0, 0, 1};
    bit er[3] = '{0, 0, 1};
    int ec[3] = '{0, 0, 1};
    logic [25:0] want;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 10, 32);
      want = {WIDTH'(ev[k]), es[k], er[k], 16'(ec[k])};
      tests_run++;
      if ({bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count} !== want) begin
        tests_failed++;
        $display("FAIL basic_spike step %0d: got %h want %h", k, {bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count}, want);
      end
    end
  endtask

  task automatic test_refractory();
    int ev[3] = '{-20, -20, -20};
    bit es[3] = '{0, 0, 1};
    bit er[3] = '{1, 0, 1};
    int ec[3] = '{1, 1, 2};
    logic [25:0] want;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 100, 32);
      want = {WIDTH'(ev[k]), es[k], er[k], 16'(ec[k])};
      tests_run++;
      if ({bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count} !== want) begin
        tests_failed++;
        $display("FAIL refractory step %0d: got %h want %h", k, {bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count}, want);
      end
    end
  endtask

  task automatic test_cancel();
    logic [25:0] want;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, -100, 32);
      want = {WIDTH'(-20), 1'b0, (k == 0), 16'd2};
      tests_run++;
      if ({bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count} !== want) begin
        tests_failed++;
        $display("FAIL cancel step %0d: got %h want %h", k, {bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count}, want);
      end
    end
  endtask

  task automatic test_saturate();
    int ev[2] = '{-100, -128};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, -100, 0);
      tests_run++;
      if ({bus_a.V_mem, bus_a.spike} !== {WIDTH'(ev[k]), 1'b0}) begin
        tests_failed++;
        $display("FAIL saturate step %0d: got V=%0d spike=%0b want V=%0d spike=0", k, bus_a.V_mem, bus_a.spike, ev[k]);
      end
    end
  endtask

  task automatic test_hold();
    bit en[4] = '{1, 0, 0, 1};
    int ev[4] = '{10, 10, 10, 20};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(en[k], 10, 0);
      tests_run++;
      if ({bus_a.V_mem, bus_a.spike} !== {WIDTH'(ev[k]), 1'b0}) begin
        tests_failed++;
        $display("FAIL hold step %0d: got V=%0d spike=%0b want V=%0d spike=0", k, bus_a.V_mem, bus_a.spike, ev[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 100, 0);
    tests_run++;
    if ({bus_a.refractory, bus_b.spike} !== 2'b11) begin
      tests_failed++;
      $display("FAIL async_setup: got refr_a=%0b spike_b=%0b want 1 1", bus_a.refractory, bus_b.spike);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count, bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count}
        !== {WIDTH'(V_INIT), 1'b0, 1'b0, 16'd0, WIDTH'(V_INIT), 1'b0, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: got a=%h b=%h want V_INIT and zeros", {bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count}, {bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(1'b1, 10, 0);
    tests_run++;
    if ({bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count} !== exp_a()) begin
      tests_failed++;
      $display("FAIL async_restart: got %h want %h", {bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count}, exp_a());
    end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 100, 0);
      tests_run++;
      if ({bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count} !== exp_b() || bus_b.spike !== 1'b1) begin
        tests_failed++;
        $display("FAIL back_to_back step %0d: got %h want %h", k, {bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count}, exp_b());
      end
    end
    tests_run++;
    if (bus_b.spike_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL count_wrap: got %0d want 1", bus_b.spike_count);
    end
  endtask

  task automatic test_random();
    bit en;
    int i;
    int g;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (k % 100 == 99) do_reset();
      en = ($urandom_range(0, 3) != 0);
      i  = int'($urandom_range(0, 255)) - 128;
      g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      drive(en, i, g);
      tests_run++;
      if ({bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count} !== exp_a()) begin
        tests_failed++;
        $display("FAIL random_a cycle %0d: got %h want %h", k, {bus_a.V_mem, bus_a.spike, bus_a.refractory, bus_a.spike_count}, exp_a());
      end
      tests_run++;
      if ({bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count} !== exp_b()) begin
        tests_failed++;
        $display("FAIL random_b cycle %0d: got %h want %h", k, {bus_b.V_mem, bus_b.spike, bus_b.refractory, bus_b.spike_count}, exp_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_spike();
    test_refractory();
    test_cancel();
    test_saturate();
    test_hold();
    test_async_reset();
    test_back_to_back_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
